// File: rtl/sd_rd_arbiter.sv
// Round-robin arbiter sharing the sd_fat_reader sector-read port between the two floppy drives.
// Sequences rstart/rbusy/rdone, routes the byte stream to the winner and aborts a stalled card.
module sd_rd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 3_200_000,
  parameter int unsigned START_WAIT     = 64
) (
  input  logic        clk_32,
  input  logic        reset,
  input  logic [1:0]  img_mounted,
  input  logic [1:0]  req_rd,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  output logic [1:0]  drv_ack,
  output logic [1:0]  drv_done,
  output logic [1:0]  drv_err,
  output logic [1:0]  buf_strobe,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_data,
  output logic        busy,
  output logic        rstart,
  output logic [31:0] rsector,
  input  logic        rbusy,
  input  logic        rdone,
  input  logic        outen,
  input  logic [8:0]  outaddr,
  input  logic [7:0]  outbyte
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW_W = $clog2(START_WAIT + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, XFER, DONE} state_t;

  state_t          state, state_n;
  logic            cur, cur_n;
  logic            last_grant, last_grant_n;
  logic [1:0]      armed, armed_n;
  logic [WD_W-1:0] wd, wd_n;
  logic [SW_W-1:0] sw, sw_n;
  logic [1:0]      ack_n, done_n, err_n, strobe_n;
  logic [8:0]      addr_n;
  logic [7:0]      data_n;
  logic            rstart_n;
  logic [31:0]     rsector_n;
  logic [1:0]      eligible;
  logic            grant_sel;
  logic            timeout;
  logic            abort;

  always_comb begin
    state_n      = state;
    cur_n        = cur;
    last_grant_n = last_grant;
    armed_n      = armed;
    wd_n         = wd;
    sw_n         = sw;
    ack_n        = drv_ack;
    done_n       = '0;
    strobe_n     = '0;
    addr_n       = buf_addr;
    data_n       = buf_data;
    rstart_n     = rstart;
    rsector_n    = rsector;
    grant_sel    = 1'b0;
    abort        = 1'b0;
    eligible     = req_rd & img_mounted & armed;
    timeout      = (wd == WD_W'(TIMEOUT_CYCLES - 1));

    if (state != IDLE) wd_n = wd + 1'b1;

    case (state)
      IDLE: begin
        if (eligible != 2'b00) begin
          grant_sel    = (eligible == 2'b11) ? ~last_grant : eligible[1];
          cur_n        = grant_sel;
          last_grant_n = grant_sel;
          rsector_n    = grant_sel ? req_lba1 : req_lba0;
          ack_n        = grant_sel ? 2'b10 : 2'b01;
          wd_n         = '0;
          state_n      = START;
        end
      end
      START: begin
        rstart_n = 1'b1;
        sw_n     = '0;
        state_n  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (rbusy) begin
          rstart_n = 1'b0;
          state_n  = XFER;
        end else if (sw == SW_W'(START_WAIT - 1)) begin
          abort = 1'b1;
        end else begin
          sw_n = sw + 1'b1;
        end
      end
      XFER: begin
        if (rdone) state_n = DONE;
      end
      DONE: begin
        done_n[cur] = 1'b1;
        ack_n       = '0;
        armed_n[cur] = 1'b0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Watchdog covers the whole grant; a coincident rdone takes precedence.
    if (timeout && (state == START || state == WAIT_BUSY || (state == XFER && !rdone)))
      abort = 1'b1;

    if (abort) begin
      ack_n        = '0;
      rstart_n     = 1'b0;
      armed_n[cur] = 1'b0;
      state_n      = IDLE;
    end

    err_n = req_rd & ~img_mounted;
    if (abort) err_n[cur] = 1'b1;

    if (state == WAIT_BUSY || state == XFER) begin
      strobe_n[cur] = outen;
      addr_n        = outaddr;
      data_n        = outbyte;
    end

    for (int unsigned i = 0; i < 2; i++)
      if (!req_rd[i]) armed_n[i] = 1'b1;
  end

  always_ff @(posedge clk_32 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= 1'b0;
      last_grant <= 1'b1;
      armed      <= 2'b11;
      wd         <= '0;
      sw         <= '0;
      drv_ack    <= '0;
      drv_done   <= '0;
      drv_err    <= '0;
      buf_strobe <= '0;
      buf_addr   <= '0;
      buf_data   <= '0;
      busy       <= 1'b0;
      rstart     <= 1'b0;
      rsector    <= '0;
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      last_grant <= last_grant_n;
      armed      <= armed_n;
      wd         <= wd_n;
      sw         <= sw_n;
      drv_ack    <= ack_n;
      drv_done   <= done_n;
      drv_err    <= err_n;
      buf_strobe <= strobe_n;
      buf_addr   <= addr_n;
      buf_data   <= data_n;
      busy       <= (state_n != IDLE);
      rstart     <= rstart_n;
      rsector    <= rsector_n;
    end
  end

endmodule

// File: tb/tb_sd_rd_arbiter.sv
// Bench for sd_rd_arbiter: behavioural sd_fat_reader model plus a byte scoreboard.
module tb_sd_rd_arbiter;

  localparam int unsigned TO = 1000;
  localparam int unsigned SW = 64;

  logic        clk_32 = 1'b0;
  logic        reset;
  logic [1:0]  img_mounted, req_rd;
  logic [31:0] req_lba0, req_lba1;
  logic [1:0]  drv_ack, drv_done, drv_err, buf_strobe;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_data;
  logic        busy, rstart;
  logic [31:0] rsector;
  logic        rbusy, rdone, outen;
  logic [8:0]  outaddr;
  logic [7:0]  outbyte;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] strobe;
    logic [8:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned grant_q[$];
  int          rd_mode = 0;   // 0 normal, 1 stall after rbusy, 2 ignore rstart
  int          rd_phase = 0;
  int unsigned rd_idx = 0;
  int unsigned rd_drv = 0;
  logic [31:0] rd_lba = '0;
  int unsigned strobe_cnt [2] = '{0, 0};
  bit          ack_multi = 1'b0;
  exp_t        mon_e;
  exp_t        rd_e;

  always #15 clk_32 = ~clk_32;

  sd_rd_arbiter #(.TIMEOUT_CYCLES(TO), .START_WAIT(SW)) dut (
    .clk_32(clk_32), .reset(reset), .img_mounted(img_mounted), .req_rd(req_rd),
    .req_lba0(req_lba0), .req_lba1(req_lba1), .drv_ack(drv_ack), .drv_done(drv_done),
    .drv_err(drv_err), .buf_strobe(buf_strobe), .buf_addr(buf_addr), .buf_data(buf_data),
    .busy(busy), .rstart(rstart), .rsector(rsector), .rbusy(rbusy), .rdone(rdone),
    .outen(outen), .outaddr(outaddr), .outbyte(outbyte)
  );

  function automatic logic [7:0] byte_of(input logic [31:0] lba, input int unsigned idx);
    logic [8:0] a;
    a = idx[8:0];
    return lba[7:0] ^ a[7:0] ^ {7'b0, a[8]} ^ 8'h5a;
  endfunction

  // Reader model: latches the expected grant at rstart and streams 512 bytes, rdone on the last.
  initial begin
    rbusy = 1'b0; rdone = 1'b0; outen = 1'b0; outaddr = '0; outbyte = '0;
    forever begin
      @(negedge clk_32);
      rdone = 1'b0;
      outen = 1'b0;
      if (reset || (!busy && rd_phase == 1)) begin
        rbusy    = 1'b0;
        rd_phase = 0;
      end else begin
        case (rd_phase)
          0: if (rstart && rd_mode != 2) begin
            checks++;
            if (grant_q.size() == 0) begin
              errors++;
              rd_drv = 0;
              $display("FAIL grant_order: rstart with no grant expected, ack=%b", drv_ack);
            end else begin
              rd_drv = grant_q.pop_front();
              if (drv_ack !== ((rd_drv == 1) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL grant_order: ack=%b expected drive %0d", drv_ack, rd_drv);
              end
            end
            checks++;
            if (rsector !== ((rd_drv == 1) ? req_lba1 : req_lba0)) begin
              errors++;
              $display("FAIL rsector: got %h expected %h", rsector,
                       (rd_drv == 1) ? req_lba1 : req_lba0);
            end
            rd_lba   = rsector;
            rd_idx   = 0;
            rbusy    = 1'b1;
            rd_phase = 1;
          end
          1: if (rd_mode != 1) begin
            outen   = 1'b1;
            outaddr = rd_idx[8:0];
            outbyte = byte_of(rd_lba, rd_idx);
            rd_e.strobe = (rd_drv == 1) ? 2'b10 : 2'b01;
            rd_e.addr   = rd_idx[8:0];
            rd_e.data   = byte_of(rd_lba, rd_idx);
            sb_q.push_back(rd_e);
            if (rd_idx == 511) begin
              rdone    = 1'b1;
              rd_phase = 2;
            end
            rd_idx++;
          end
          default: begin
            rbusy    = 1'b0;
            rd_phase = 0;
          end
        endcase
      end
    end
  end

  // Scoreboard: every forwarded byte must match the oldest byte the reader emitted.
  initial begin
    forever begin
      @(negedge clk_32);
      if (!reset && drv_ack == 2'b11) ack_multi = 1'b1;
      if (!reset && buf_strobe != 2'b00) begin
        if (buf_strobe[0]) strobe_cnt[0]++;
        if (buf_strobe[1]) strobe_cnt[1]++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL byte_unexpected: strobe=%b addr=%0d data=%h, none expected",
                   buf_strobe, buf_addr, buf_data);
        end else begin
          mon_e = sb_q.pop_front();
          if (buf_strobe !== mon_e.strobe || buf_addr !== mon_e.addr || buf_data !== mon_e.data) begin
            errors++;
            $display("FAIL byte: got strobe=%b addr=%0d data=%h expected strobe=%b addr=%0d data=%h",
                     buf_strobe, buf_addr, buf_data, mon_e.strobe, mon_e.addr, mon_e.data);
          end
        end
      end
    end
  end

  task automatic wait_any_done(input int unsigned budget, output bit seen);
    seen = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk_32);
      if (drv_done != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({drv_ack, drv_done, drv_err, buf_strobe} !== 8'h00) begin
      errors++;
      $display("FAIL reset_drv: ack=%b done=%b err=%b strobe=%b expected all 0",
               drv_ack, drv_done, drv_err, buf_strobe);
    end
    checks++;
    if ({buf_addr, buf_data} !== 17'h0) begin
      errors++;
      $display("FAIL reset_buf: addr=%0d data=%h expected 0", buf_addr, buf_data);
    end
    checks++;
    if ({busy, rstart, rsector} !== 34'h0) begin
      errors++;
      $display("FAIL reset_reader: busy=%b rstart=%b rsector=%h expected 0", busy, rstart, rsector);
    end
    repeat (3) @(negedge clk_32);
    reset = 1'b0;
    @(negedge clk_32);
    checks++;
    if (busy !== 1'b0 || drv_ack !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy=%b ack=%b expected 0/00", busy, drv_ack);
    end
  endtask

  task automatic test_single_read();
    bit seen;
    bit regrant;
    int unsigned n0, n1;
    img_mounted = 2'b11;
    req_lba0 = 32'h0000_0123;
    req_lba1 = 32'h0000_0456;
    n0 = strobe_cnt[0];
    n1 = strobe_cnt[1];
    grant_q.push_back(0);
    req_rd = 2'b01;
    @(negedge clk_32);
    checks++;
    if ({drv_ack, rstart, busy} !== 4'b0101) begin
      errors++;
      $display("FAIL grant_latency: ack=%b rstart=%b busy=%b expected 01/0/1", drv_ack, rstart, busy);
    end
    @(negedge clk_32);
    checks++;
    if (rstart !== 1'b1) begin
      errors++;
      $display("FAIL rstart_latency: rstart=%b expected 1", rstart);
    end
    wait_any_done(2000, seen);
    checks++;
    if (!seen || drv_done !== 2'b01 || drv_ack !== 2'b00) begin
      errors++;
      $display("FAIL single_done: seen=%b done=%b ack=%b expected 1/01/00", seen, drv_done, drv_ack);
    end
    regrant = 1'b0;
    repeat (10) begin
      @(negedge clk_32);
      if (busy || drv_done != 2'b00) regrant = 1'b1;
    end
    checks++;
    if (regrant) begin
      errors++;
      $display("FAIL stale_request: stale request re-granted, busy=%b", busy);
    end
    checks++;
    if (strobe_cnt[0] - n0 != 512 || strobe_cnt[1] != n1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL single_count: strobe0=%0d strobe1=%0d pending=%0d expected 512/0/0",
               strobe_cnt[0] - n0, strobe_cnt[1] - n1, sb_q.size());
    end
    req_rd = 2'b00;
    repeat (2) @(negedge clk_32);
  endtask

  task automatic test_contention();
    bit seen;
    req_lba0 = 32'h0000_0a10;
    req_lba1 = 32'h0000_0b21;
    reset = 1'b1;
    req_rd = 2'b11;
    grant_q.push_back(0);
    grant_q.push_back(1);
    repeat (2) @(negedge clk_32);
    reset = 1'b0;
    wait_any_done(2000, seen);
    checks++;
    if (!seen || drv_done !== 2'b01) begin
      errors++;
      $display("FAIL contention_first: seen=%b done=%b expected 01", seen, drv_done);
    end
    @(negedge clk_32);
    checks++;
    if (drv_ack !== 2'b10) begin
      errors++;
      $display("FAIL back_to_back: ack=%b one cycle after done, expected 10", drv_ack);
    end
    wait_any_done(2000, seen);
    checks++;
    if (!seen || drv_done !== 2'b10) begin
      errors++;
      $display("FAIL contention_second: seen=%b done=%b expected 10", seen, drv_done);
    end
    req_rd = 2'b00;
    repeat (2) @(negedge clk_32);
    grant_q.push_back(0);
    grant_q.push_back(1);
    req_rd = 2'b11;
    wait_any_done(2000, seen);
    checks++;
    if (!seen || drv_done !== 2'b01) begin
      errors++;
      $display("FAIL round_robin: seen=%b done=%b expected 01", seen, drv_done);
    end
    wait_any_done(2000, seen);
    checks++;
    if (!seen || drv_done !== 2'b10) begin
      errors++;
      $display("FAIL round_robin_second: seen=%b done=%b expected 10", seen, drv_done);
    end
    req_rd = 2'b00;
    repeat (2) @(negedge clk_32);
    checks++;
    if (sb_q.size() != 0 || grant_q.size() != 0 || ack_multi) begin
      errors++;
      $display("FAIL contention_drain: pending bytes=%0d grants=%0d ack_multi=%b expected 0/0/0",
               sb_q.size(), grant_q.size(), ack_multi);
    end
  endtask

  task automatic test_unmounted();
    bit started;
    img_mounted = 2'b10;
    req_rd = 2'b01;
    repeat (2) @(negedge clk_32);
    checks++;
    if (drv_err !== 2'b01) begin
      errors++;
      $display("FAIL unmounted_err: err=%b expected 01", drv_err);
    end
    started = 1'b0;
    repeat (20) begin
      @(negedge clk_32);
      if (rstart || busy || drv_ack != 2'b00 || drv_err != 2'b01) started = 1'b1;
    end
    checks++;
    if (started) begin
      errors++;
      $display("FAIL unmounted_grant: rstart=%b busy=%b ack=%b err=%b expected 0/0/00/01",
               rstart, busy, drv_ack, drv_err);
    end
    req_rd = 2'b00;
    repeat (2) @(negedge clk_32);
    checks++;
    if (drv_err !== 2'b00) begin
      errors++;
      $display("FAIL unmounted_release: err=%b expected 00", drv_err);
    end
    img_mounted = 2'b11;
  endtask

  task automatic test_stall();
    bit seen;
    bit acked;
    int unsigned cyc;
    rd_mode = 1;
    grant_q.push_back(1);
    req_rd = 2'b10;
    acked = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk_32);
      if (drv_ack == 2'b10) begin
        acked = 1'b1;
        break;
      end
    end
    seen = 1'b0;
    cyc = 0;
    for (int unsigned i = 1; i <= TO + 100; i++) begin
      @(negedge clk_32);
      if (drv_err != 2'b00) begin
        seen = 1'b1;
        cyc = i;
        break;
      end
    end
    checks++;
    if (!acked || !seen || drv_err !== 2'b10 || drv_ack !== 2'b00) begin
      errors++;
      $display("FAIL stall_abort: acked=%b seen=%b err=%b ack=%b expected 1/1/10/00",
               acked, seen, drv_err, drv_ack);
    end
    checks++;
    if (cyc < TO - 1 || cyc > TO) begin
      errors++;
      $display("FAIL stall_timing: err after %0d cycles from grant, expected %0d..%0d", cyc, TO - 1, TO);
    end
    req_rd = 2'b00;
    @(negedge clk_32);
    checks++;
    if (drv_err !== 2'b00 || busy !== 1'b0 || rstart !== 1'b0) begin
      errors++;
      $display("FAIL stall_pulse: err=%b busy=%b rstart=%b expected 00/0/0", drv_err, busy, rstart);
    end
    rd_mode = 0;
    repeat (2) @(negedge clk_32);
    grant_q.push_back(0);
    req_rd = 2'b01;
    wait_any_done(2000, seen);
    checks++;
    if (!seen || drv_done !== 2'b01) begin
      errors++;
      $display("FAIL stall_recover: seen=%b done=%b expected 01", seen, drv_done);
    end
    req_rd = 2'b00;
    repeat (2) @(negedge clk_32);
  endtask

  task automatic test_no_busy();
    bit seen;
    int unsigned hi;
    rd_mode = 2;
    req_rd = 2'b01;
    seen = 1'b0;
    hi = 0;
    for (int unsigned i = 0; i < 300; i++) begin
      @(negedge clk_32);
      if (rstart) hi++;
      if (drv_err != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || drv_err !== 2'b01 || drv_ack !== 2'b00 || rstart !== 1'b0) begin
      errors++;
      $display("FAIL no_busy_abort: seen=%b err=%b ack=%b rstart=%b expected 1/01/00/0",
               seen, drv_err, drv_ack, rstart);
    end
    checks++;
    if (hi != SW) begin
      errors++;
      $display("FAIL no_busy_hold: rstart held %0d cycles, expected %0d", hi, SW);
    end
    req_rd = 2'b00;
    repeat (3) @(negedge clk_32);
    rd_mode = 0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit reached;
    int unsigned n0;
    req_lba0 = 32'h0000_0777;
    n0 = strobe_cnt[0];
    grant_q.push_back(0);
    req_rd = 2'b01;
    reached = 1'b0;
    for (int unsigned i = 0; i < 1000; i++) begin
      @(negedge clk_32);
      if (strobe_cnt[0] - n0 >= 200) begin
        reached = 1'b1;
        break;
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (!reached || {drv_ack, drv_done, drv_err, buf_strobe, buf_addr, buf_data,
                     busy, rstart, rsector} !== 59'h0) begin
      errors++;
      $display("FAIL reset_mid: reached=%b ack=%b strobe=%b addr=%0d busy=%b rstart=%b rsector=%h expected all 0",
               reached, drv_ack, buf_strobe, buf_addr, busy, rstart, rsector);
    end
    #1;
    sb_q.delete();
    grant_q.delete();
    repeat (2) @(negedge clk_32);
    grant_q.push_back(0);
    reset = 1'b0;
    wait_any_done(2000, seen);
    checks++;
    if (!seen || drv_done !== 2'b01) begin
      errors++;
      $display("FAIL reset_regrant: seen=%b done=%b expected 01", seen, drv_done);
    end
    req_rd = 2'b00;
    repeat (2) @(negedge clk_32);
    checks++;
    if (sb_q.size() != 0 || grant_q.size() != 0) begin
      errors++;
      $display("FAIL reset_drain: pending bytes=%0d grants=%0d expected 0/0", sb_q.size(), grant_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    img_mounted = 2'b11;
    req_rd = 2'b00;
    req_lba0 = '0;
    req_lba1 = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_unmounted();
    test_stall();
    test_no_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
